// File: rtl/input_port_pkg.sv
// rtl/input_port_pkg.sv - shared bus width and default input FIFO depth
package input_port_pkg;

  localparam int IP_WIDTH = 16;
  localparam int IP_DEPTH = 4;

  typedef enum logic [1:0] {
    OP_IDLE = 2'b00,
    OP_POP  = 2'b01,
    OP_PUSH = 2'b10,
    OP_BOTH = 2'b11
  } fifo_op_e;

endpackage

// File: rtl/fifo_ram.sv
// rtl/fifo_ram.sv - DEPTH x WIDTH storage, one write port, async read, no reset
module fifo_ram
  import input_port_pkg::*;
#(
  parameter int DEPTH = IP_DEPTH,
  parameter int WIDTH = IP_WIDTH,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             i_we,
  input  logic [AW-1:0]    i_waddr,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic [AW-1:0]    i_raddr,
  output logic [WIDTH-1:0] o_rdata
);

  logic [WIDTH-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/input_port.sv
// rtl/input_port.sv - producer-facing input FIFO popped onto the CPU bus by ctl_in
module input_port
  import input_port_pkg::*;
#(
  parameter int DEPTH = IP_DEPTH,
  parameter int WIDTH = IP_WIDTH
) (
  input  logic             clk,
  input  logic             reset_raw,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             ctl_in,
  output logic [WIDTH-1:0] bus_out,
  output logic             in_empty,
  output logic             in_full,
  output logic             in_underflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  generate
    if (DEPTH < 2 || DEPTH > 16 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
      $error("input_port: DEPTH must be a power of two in 2..16");
    end
  endgenerate

  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             r_underflow;

  logic             w_state_empty;
  logic             w_state_full;
  logic             w_push;
  logic             w_pop;
  logic [WIDTH-1:0] w_head;
  fifo_op_e         w_op;

  assign w_state_empty = (r_count == '0);
  assign w_state_full  = (r_count == CW'(DEPTH));

  // Status outputs are gated by reset so the producer sees a closed port while held in reset.
  assign in_ready     = reset_raw && !w_state_full;
  assign in_empty     = !reset_raw || w_state_empty;
  assign in_full      = reset_raw && w_state_full;
  assign in_underflow = r_underflow;

  assign w_push = in_valid && in_ready;
  assign w_pop  = reset_raw && ctl_in && !w_state_empty;
  assign w_op   = fifo_op_e'({w_push, w_pop});

  fifo_ram #(
    .DEPTH (DEPTH),
    .WIDTH (WIDTH)
  ) u_ram (
    .clk     (clk),
    .i_we    (w_push),
    .i_waddr (r_wr_ptr),
    .i_wdata (in_data),
    .i_raddr (r_rd_ptr),
    .o_rdata (w_head)
  );

  assign bus_out = w_pop ? w_head : '0;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (!reset_raw) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_underflow <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      if (ctl_in && w_state_empty) r_underflow <= 1'b1;
      case (w_op)
        OP_PUSH: r_count <= r_count + CW'(1);
        OP_POP:  r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: tb/tb_input_port.sv
// tb/tb_input_port.sv - scoreboard bench for input_port
module tb_input_port;

  localparam int DEPTH = 4;
  localparam int WIDTH = 16;

  logic             clk = 1'b0;
  logic             reset_raw;
  logic [WIDTH-1:0] in_data;
  logic             in_valid;
  logic             in_ready;
  logic             ctl_in;
  logic [WIDTH-1:0] bus_out;
  logic             in_empty;
  logic             in_full;
  logic             in_underflow;

  int total = 0;
  int bad   = 0;
  logic [WIDTH-1:0] q[$];
  logic             m_flag = 1'b0;

  input_port #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
    .clk          (clk),
    .reset_raw    (reset_raw),
    .in_data      (in_data),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .ctl_in       (ctl_in),
    .bus_out      (bus_out),
    .in_empty     (in_empty),
    .in_full      (in_full),
    .in_underflow (in_underflow)
  );

  always #5 clk = ~clk;

  function automatic logic [WIDTH-1:0] exp_bus();
    return (reset_raw && ctl_in && q.size() > 0) ? q[0] : '0;
  endfunction

  // Called at posedge+1; returns at the falling edge where outputs are sampled.
  task automatic drive(input logic v, input logic [WIDTH-1:0] d, input logic c);
    in_valid = v;
    in_data  = d;
    ctl_in   = c;
    #4;
  endtask

  task automatic tick();
    int n;
    @(posedge clk);
    n = q.size();
    if (!reset_raw) begin
      q.delete();
      m_flag = 1'b0;
    end else begin
      if (ctl_in && n == 0) m_flag = 1'b1;
      if (ctl_in && n > 0) void'(q.pop_front());
      if (in_valid && n < DEPTH) q.push_back(in_data);
    end
    #1;
  endtask

  task automatic test_reset();
    reset_raw = 1'b0;
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, 16'h1111, 1'b1);
      total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL reset_ready act=%b exp=0", in_ready); end
      total++; if (in_empty !== 1'b1) begin bad++; $display("FAIL reset_empty act=%b exp=1", in_empty); end
      total++; if (in_full !== 1'b0) begin bad++; $display("FAIL reset_full act=%b exp=0", in_full); end
      total++; if (bus_out !== 16'h0000) begin bad++; $display("FAIL reset_bus act=%h exp=0000", bus_out); end
      tick();
    end
    total++; if (in_underflow !== 1'b0) begin bad++; $display("FAIL reset_uflow act=%b exp=0", in_underflow); end
    reset_raw = 1'b1;
    drive(1'b0, '0, 1'b0);
    tick();
  endtask

  task automatic test_basic();
    logic [WIDTH-1:0] words [2];
    words[0] = 16'h1234;
    words[1] = 16'hABCD;
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, words[i], 1'b0);
      total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL basic_ready act=%b exp=1", in_ready); end
      tick();
    end
    drive(1'b0, '0, 1'b0);
    total++; if (in_empty !== 1'b0) begin bad++; $display("FAIL basic_notempty act=%b exp=0", in_empty); end
    for (int i = 0; i < 2; i++) begin
      drive(1'b0, '0, 1'b1);
      total++; if (bus_out !== words[i]) begin bad++; $display("FAIL basic_bus act=%h exp=%h", bus_out, words[i]); end
      tick();
    end
    drive(1'b0, '0, 1'b0);
    total++; if (in_empty !== 1'b1) begin bad++; $display("FAIL basic_empty act=%b exp=1", in_empty); end
    tick();
  endtask

  task automatic test_full();
    for (int i = 1; i <= 4; i++) begin
      drive(1'b1, WIDTH'(i), 1'b0);
      tick();
    end
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, 16'h0005, 1'b0);
      total++; if (in_full !== 1'b1) begin bad++; $display("FAIL full_flag act=%b exp=1", in_full); end
      total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL full_ready act=%b exp=0", in_ready); end
      tick();
    end
    drive(1'b1, 16'h0005, 1'b1);
    total++; if (bus_out !== 16'h0001) begin bad++; $display("FAIL full_pop act=%h exp=0001", bus_out); end
    tick();
    drive(1'b1, 16'h0005, 1'b0);
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL full_reopen act=%b exp=1", in_ready); end
    tick();
    for (int i = 2; i <= 5; i++) begin
      drive(1'b0, '0, 1'b1);
      total++; if (bus_out !== WIDTH'(i) || bus_out !== exp_bus()) begin bad++; $display("FAIL full_order act=%h exp=%h", bus_out, WIDTH'(i)); end
      tick();
    end
    drive(1'b0, '0, 1'b0);
    total++; if (in_empty !== 1'b1 || q.size() != 0) begin bad++; $display("FAIL full_drain act=%b exp=1 q=%0d", in_empty, q.size()); end
    tick();
  endtask

  task automatic test_underflow();
    drive(1'b0, '0, 1'b1);
    total++; if (bus_out !== 16'h0000) begin bad++; $display("FAIL uflow_bus act=%h exp=0000", bus_out); end
    tick();
    for (int i = 0; i < 4; i++) begin
      drive(i < 2, WIDTH'(16'h0C00 + i), i >= 2);
      total++; if (in_underflow !== 1'b1) begin bad++; $display("FAIL uflow_sticky act=%b exp=1", in_underflow); end
      total++; if (bus_out !== exp_bus()) begin bad++; $display("FAIL uflow_data act=%h exp=%h", bus_out, exp_bus()); end
      tick();
    end
  endtask

  task automatic test_simul();
    reset_raw = 1'b0;
    drive(1'b0, '0, 1'b0);
    tick();
    reset_raw = 1'b1;
    drive(1'b1, 16'h1111, 1'b0); tick();
    drive(1'b1, 16'h2222, 1'b0); tick();
    drive(1'b1, 16'h5555, 1'b1);
    total++; if (bus_out !== 16'h1111) begin bad++; $display("FAIL simul_head act=%h exp=1111", bus_out); end
    tick();
    drive(1'b0, '0, 1'b1);
    total++; if (bus_out !== 16'h2222) begin bad++; $display("FAIL simul_2nd act=%h exp=2222", bus_out); end
    tick();
    drive(1'b0, '0, 1'b1);
    total++; if (bus_out !== 16'h5555) begin bad++; $display("FAIL simul_last act=%h exp=5555", bus_out); end
    tick();
    drive(1'b1, 16'h7777, 1'b1);
    total++; if (in_underflow !== 1'b0) begin bad++; $display("FAIL simul_noflag act=%b exp=0", in_underflow); end
    total++; if (bus_out !== 16'h0000) begin bad++; $display("FAIL simul_emptybus act=%h exp=0000", bus_out); end
    tick();
    drive(1'b0, '0, 1'b1);
    total++; if (in_underflow !== 1'b1) begin bad++; $display("FAIL simul_flag act=%b exp=1", in_underflow); end
    total++; if (bus_out !== 16'h7777) begin bad++; $display("FAIL simul_stored act=%h exp=7777", bus_out); end
    tick();
  endtask

  task automatic test_wrap();
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, WIDTH'(16'h00A0 + i), 1'b0);
      tick();
      drive(1'b0, '0, 1'b1);
      total++; if (bus_out !== WIDTH'(16'h00A0 + i)) begin bad++; $display("FAIL wrap_%0d act=%h exp=%h", i, bus_out, WIDTH'(16'h00A0 + i)); end
      tick();
    end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, WIDTH'(16'h0D00 + i), 1'b0);
      tick();
    end
    reset_raw = 1'b0;
    drive(1'b1, 16'h9999, 1'b0);
    tick();
    reset_raw = 1'b1;
    drive(1'b0, '0, 1'b0);
    total++; if (in_empty !== 1'b1) begin bad++; $display("FAIL rmid_empty act=%b exp=1", in_empty); end
    total++; if (in_underflow !== 1'b0) begin bad++; $display("FAIL rmid_uflow act=%b exp=0", in_underflow); end
    tick();
    drive(1'b1, 16'hBEEF, 1'b0); tick();
    drive(1'b1, 16'hCAFE, 1'b0); tick();
    drive(1'b0, '0, 1'b1);
    total++; if (bus_out !== 16'hBEEF) begin bad++; $display("FAIL rmid_first act=%h exp=beef", bus_out); end
    tick();
    drive(1'b0, '0, 1'b1);
    total++; if (bus_out !== 16'hCAFE) begin bad++; $display("FAIL rmid_second act=%h exp=cafe", bus_out); end
    tick();
    drive(1'b0, '0, 1'b0);
    total++; if (in_empty !== 1'b1) begin bad++; $display("FAIL rmid_drain act=%b exp=1", in_empty); end
    tick();
  endtask

  initial begin
    reset_raw = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    ctl_in    = 1'b0;
    @(posedge clk);
    #1;
    test_reset();
    test_basic();
    test_full();
    test_underflow();
    test_simul();
    test_wrap();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
